alu_wb_stage: RTL and testbench

- Execute/writeback pipeline register sitting directly downstream of the ALU.
- Captures ALU result, carry, overflow and multi-cycle flag; owns the architectural flag register (C, V, Z, N); drives the register-file write port.
- Feeds the stored C/V back to the ALU cin/vin inputs.
- Sequences multi-cycle operations (ALU mcp_out=1) by holding upstream for extra cycles before sampling the result.

---
 rtl/alu_wb_stage.sv | 131 +++++++++++++
 tb/tb_alu_wb_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage.sv
// Execute/writeback register behind the ALU: owns the C/V/Z/N flags, drives the register-file write port,
// and sequences multi-cycle ALU ops. Optional forwarding/flag-bypass outputs under `ALU_WB_FWD_EN`.
module alu_wb_stage #(
  parameter int REG_AW     = 4,
  parameter int MCP_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_wen,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic              ex_setflags,
  input  logic [31:0]       ex_dout,
  input  logic              ex_cout,
  input  logic              ex_vout,
  input  logic              ex_mcp,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [31:0]       wb_wdata,
  output logic              flag_c,
  output logic              flag_v,
  output logic              flag_z,
  output logic              flag_n,
  output logic              busy
`ifdef ALU_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [31:0]       fwd_data,
  output logic              flag_c_byp,
  output logic              flag_v_byp
`endif
);

  localparam int CW = $clog2(MCP_CYCLES) + 2;
  localparam logic [CW-1:0] CNT_INIT = CW'(MCP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_wb_wen;
  logic [REG_AW-1:0] r_wb_waddr;
  logic [31:0]       r_wb_wdata;
  logic              r_c, r_v, r_z, r_n;

  logic w_ready;
  logic w_capture;

  // In WAIT the ALU result is only trusted on the last cycle of the op.
  always_comb begin
    w_ready = 1'b1;
    if (r_state == S_IDLE) w_ready = !(ex_valid & ex_mcp);
    else                   w_ready = (r_cnt == CNT_ONE);
  end

  assign w_capture = ex_valid & w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_wb_wen   <= 1'b0;
      r_wb_waddr <= '0;
      r_wb_wdata <= '0;
      r_c        <= 1'b0;
      r_v        <= 1'b0;
      r_z        <= 1'b0;
      r_n        <= 1'b0;
    end else begin
      r_wb_wen <= 1'b0;
      if (w_capture) begin
        r_wb_wen   <= ex_wen;
        r_wb_waddr <= ex_waddr;
        r_wb_wdata <= ex_dout;
        if (ex_setflags) begin
          r_c <= ex_cout;
          r_v <= ex_vout;
          r_z <= (ex_dout == 32'd0);
          r_n <= ex_dout[31];
        end
      end
      case (r_state)
        S_IDLE: begin
          if (ex_valid & ex_mcp) begin
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          // Dropping ex_valid abandons the op; the last-cycle capture also lands here.
          if (!ex_valid || (r_cnt == CNT_ONE)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ex_ready = w_ready;
  assign wb_wen   = r_wb_wen;
  assign wb_waddr = r_wb_waddr;
  assign wb_wdata = r_wb_wdata;
  assign flag_c   = r_c;
  assign flag_v   = r_v;
  assign flag_z   = r_z;
  assign flag_n   = r_n;
  assign busy     = r_busy;

`ifdef ALU_WB_FWD_EN
  assign fwd_valid  = r_wb_wen;
  assign fwd_addr   = r_wb_waddr;
  assign fwd_data   = r_wb_wdata;
  assign flag_c_byp = (w_capture & ex_setflags) ? ex_cout : r_c;
  assign flag_v_byp = (w_capture & ex_setflags) ? ex_vout : r_v;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios then random op mix, checked against
// a transaction-level model of the writeback port and flag register.
module tb_alu_wb_stage;
  localparam int REG_AW = 4;
  localparam int MCP    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_valid, ex_ready, ex_wen, ex_setflags, ex_cout, ex_vout, ex_mcp;
  logic [REG_AW-1:0] ex_waddr;
  logic [31:0]       ex_dout;
  logic              wb_wen;
  logic [REG_AW-1:0] wb_waddr;
  logic [31:0]       wb_wdata;
  logic              flag_c, flag_v, flag_z, flag_n, busy;
`ifdef ALU_WB_FWD_EN
  logic              fwd_valid, flag_c_byp, flag_v_byp;
  logic [REG_AW-1:0] fwd_addr;
  logic [31:0]       fwd_data;
`endif

  alu_wb_stage #(.REG_AW(REG_AW), .MCP_CYCLES(MCP)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wen(ex_wen), .ex_waddr(ex_waddr),
    .ex_setflags(ex_setflags), .ex_dout(ex_dout), .ex_cout(ex_cout), .ex_vout(ex_vout),
    .ex_mcp(ex_mcp), .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n), .busy(busy)
`ifdef ALU_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .flag_c_byp(flag_c_byp), .flag_v_byp(flag_v_byp)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Expected architectural state after the most recent edge.
  logic              m_wen;
  logic [REG_AW-1:0] m_addr;
  logic [31:0]       m_data;
  logic              m_c, m_v, m_z, m_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wen = 0; m_addr = '0; m_data = '0;
    m_c = 0; m_v = 0; m_z = 0; m_n = 0;
  endtask

  task automatic model_accept(input logic wen, input logic [REG_AW-1:0] addr, input logic sf,
                              input logic [31:0] dout, input logic c, input logic v);
    m_wen = wen; m_addr = addr; m_data = dout;
    if (sf) begin
      m_c = c; m_v = v; m_z = (dout == 0); m_n = dout[31];
    end
  endtask

  task automatic check_out(input string tag, input logic exp_busy);
    chk({tag, ".wen"},   wb_wen,   m_wen);
    chk({tag, ".waddr"}, wb_waddr, m_addr);
    chk({tag, ".wdata"}, wb_wdata, m_data);
    chk({tag, ".c"},     flag_c,   m_c);
    chk({tag, ".v"},     flag_v,   m_v);
    chk({tag, ".z"},     flag_z,   m_z);
    chk({tag, ".n"},     flag_n,   m_n);
    chk({tag, ".busy"},  busy,     exp_busy);
`ifdef ALU_WB_FWD_EN
    chk({tag, ".fwd_valid"}, fwd_valid, m_wen);
    chk({tag, ".fwd_addr"},  fwd_addr,  m_addr);
    chk({tag, ".fwd_data"},  fwd_data,  m_data);
`endif
  endtask

  task automatic drive(input logic vld, input logic mcp, input logic wen, input logic [REG_AW-1:0] addr,
                       input logic sf, input logic [31:0] dout, input logic c, input logic v);
    ex_valid = vld; ex_mcp = mcp; ex_wen = wen; ex_waddr = addr;
    ex_setflags = sf; ex_dout = dout; ex_cout = c; ex_vout = v;
  endtask

  task automatic op_single(input logic wen, input logic [REG_AW-1:0] addr, input logic sf,
                           input logic [31:0] dout, input logic c, input logic v);
    @(negedge clk);
    drive(1, 0, wen, addr, sf, dout, c, v);
    #1 chk("single.ready", ex_ready, 1);
`ifdef ALU_WB_FWD_EN
    chk("single.c_byp", flag_c_byp, sf ? c : m_c);
    chk("single.v_byp", flag_v_byp, sf ? v : m_v);
`endif
    @(posedge clk); #1;
    model_accept(wen, addr, sf, dout, c, v);
    check_out("single", 0);
  endtask

  task automatic op_idle();
    @(negedge clk);
    drive(0, 1'($urandom), 1'($urandom), REG_AW'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    #1 chk("idle.ready", ex_ready, !ex_mcp ? 1 : 1);
    @(posedge clk); #1;
    m_wen = 0;
    check_out("idle", 0);
  endtask

  // abort_at=0: full op; otherwise ex_valid drops in cycle abort_at (1..MCP-1).
  task automatic op_mcp(input logic wen, input logic [REG_AW-1:0] addr, input logic sf,
                        input logic [31:0] dout, input logic c, input logic v, input int abort_at);
    for (int i = 0; i < MCP; i++) begin
      @(negedge clk);
      if (abort_at != 0 && i == abort_at) begin
        drive(0, 1, wen, addr, sf, dout, c, v);
        #1 chk("abort.ready", ex_ready, (i == MCP-1) ? 1 : 0);
        @(posedge clk); #1;
        m_wen = 0;
        check_out("abort", 0);
        return;
      end
      drive(1, 1, wen, addr, sf, dout, c, v);
      #1 chk("mcp.ready", ex_ready, (i == MCP-1) ? 1 : 0);
      @(posedge clk); #1;
      if (i == MCP-1) begin
        model_accept(wen, addr, sf, dout, c, v);
        check_out("mcp_cap", 0);
      end else begin
        m_wen = 0;
        check_out("mcp_wait", 1);
      end
    end
  endtask

  task automatic reset_in_wait();
    @(negedge clk);
    drive(1, 1, 1, 4'd9, 1, 32'hdeadbeef, 1, 1);
    @(posedge clk); #1;
    m_wen = 0;
    check_out("rw_enter", 1);
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    model_reset();
    check_out("rw_reset", 0);
    @(negedge clk);
    reset = 0;
    drive(0, 0, 0, '0, 0, '0, 0, 0);
    #1 chk("rw_post.ready", ex_ready, 1);
    @(posedge clk); #1;
    check_out("rw_post", 0);
  endtask

  initial begin
    reset = 1;
    drive(0, 0, 0, '0, 0, '0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out("reset", 0);
    chk("reset.ready", ex_ready, 1);
    reset = 0;

    op_idle();
    op_single(1, 4'd5, 1, 32'h8000_0000, 1, 1);
    op_idle();
    op_mcp(1, 4'd2, 0, 32'h0000_1234, 0, 0, 0);
    op_idle();
    op_single(1, 4'd1, 1, 32'h0000_0007, 1, 0);
    op_single(1, 4'd2, 1, 32'h0000_0000, 0, 1);
    op_single(1, 4'd3, 1, 32'h0000_0005, 1, 0);
    op_single(1, 4'd4, 0, 32'h0000_0000, 0, 1);
    op_single(0, 4'd6, 1, 32'hffff_0000, 0, 1);
    op_idle();
    op_mcp(1, 4'd7, 1, 32'h0000_0000, 1, 1, 1);
    op_idle();
    reset_in_wait();

    repeat (300) begin
      logic              wen, sf, c, v;
      logic [REG_AW-1:0] addr;
      logic [31:0]       dout;
      int                kind;
      wen  = 1'($urandom);
      sf   = 1'($urandom);
      c    = 1'($urandom);
      v    = 1'($urandom);
      addr = REG_AW'($urandom);
      dout = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      kind = $urandom_range(0, 5);
      if (kind <= 2)      op_single(wen, addr, sf, dout, c, v);
      else if (kind == 3) op_idle();
      else if (kind == 4) op_mcp(wen, addr, sf, dout, c, v, 0);
      else                op_mcp(wen, addr, sf, dout, c, v, $urandom_range(1, MCP-1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
